// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Sits between the A/B block buffers and the PE array. While sys_start is
//   high it reads one A column and one B row per cycle, then applies the
//   diagonal skew the array needs: lane r is delayed r extra cycles. Lanes
//   that carry no beat are driven with zero and valid low. Once the array
//   has drained, it raises sys_done.
//
//   Optional build macro: SKEW_FEEDER_OUTREG_EN. When it is defined, an
//   extra output register stage is added on a_west/b_north/a_vld/b_vld.
//   Every presentation time then moves one cycle later, and the drain
//   terminal count becomes 3N.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   sys_clr         synchronous core clear; has priority over sys_start
//   sys_start       level; held high for the whole compute
//   sys_done        compute complete; held until sys_start falls
//   buf_rd          read strobe to the A and B buffers
//   buf_addr        beat index k
//   a_col, b_row    A column k / B row k; valid 1 cycle after buf_rd
//   a_west,b_north  skewed west/north edge operands
//   a_vld, b_vld    per-lane valids for a_west / b_north
//   pe_clear        registered copy of sys_clr
module systolic_skew_feeder #(
    parameter int ARRAY_DIM  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            sys_clr,
    input  logic                                            sys_start,
    output logic                                            sys_done,
    output logic                                            buf_rd,
    output logic [$clog2((ARRAY_DIM > 1) ? ARRAY_DIM : 2)-1:0] buf_addr,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0]                 a_col,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0]                 b_row,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0]                 a_west,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0]                 b_north,
    output logic [ARRAY_DIM-1:0]                            a_vld,
    output logic [ARRAY_DIM-1:0]                            b_vld,
    output logic                                            pe_clear
);

    localparam int AW = $clog2((ARRAY_DIM > 1) ? ARRAY_DIM : 2);
    localparam int CW = $clog2(3 * ARRAY_DIM + 1);
`ifdef SKEW_FEEDER_OUTREG_EN
    localparam int DRAIN_LAST = 3 * ARRAY_DIM;
`else
    localparam int DRAIN_LAST = 3 * ARRAY_DIM - 1;
`endif

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            flush;
    logic            rd_vld_p0;

    // Control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (sys_clr) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sys_start) begin
                        state_n = FEED;
                        cnt_n   = '0;
                    end
                end
                FEED: begin
                    if (!sys_start) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (cnt == CW'(ARRAY_DIM - 1)) state_n = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!sys_start) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (cnt == CW'(DRAIN_LAST)) state_n = DONE;
                    end
                end
                DONE: begin
                    if (!sys_start) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign buf_rd   = (state == FEED);
    assign buf_addr = cnt[AW-1:0];

    // A clear or an abort drops everything in flight so no stale beat
    // reaches the array after the run has ended.
    assign flush = sys_clr || (((state == FEED) || (state == DRAIN)) && !sys_start);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sys_done  <= 1'b0;
            pe_clear  <= 1'b0;
            rd_vld_p0 <= 1'b0;
        end else begin
            sys_done  <= (state == DONE) && sys_start && !sys_clr;
            pe_clear  <= sys_clr;
            rd_vld_p0 <= buf_rd && !flush;
        end
    end

    // Stage p0 -> p1: per-lane skew shift registers (lane r has depth r)
    logic [DATA_WIDTH-1:0] a_sk [ARRAY_DIM];
    logic [DATA_WIDTH-1:0] b_sk [ARRAY_DIM];
    logic [ARRAY_DIM-1:0]  v_sk;

    for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_in;
        logic [DATA_WIDTH-1:0] b_in;

        // Buffer data is zero-padded whenever no read was issued last cycle.
        assign a_in = rd_vld_p0 ? a_col[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_in = rd_vld_p0 ? b_row[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        if (r == 0) begin : g_direct
            assign a_sk[r] = a_in;
            assign b_sk[r] = b_in;
            assign v_sk[r] = rd_vld_p0;
        end else begin : g_shift
            logic [DATA_WIDTH-1:0] a_sh_p1 [r];
            logic [DATA_WIDTH-1:0] b_sh_p1 [r];
            logic [r-1:0]          v_sh_p1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst || flush) begin
                    for (int j = 0; j < r; j++) begin
                        a_sh_p1[j] <= '0;
                        b_sh_p1[j] <= '0;
                    end
                    v_sh_p1 <= '0;
                end else begin
                    a_sh_p1[0] <= a_in;
                    b_sh_p1[0] <= b_in;
                    v_sh_p1[0] <= rd_vld_p0;
                    for (int j = 1; j < r; j++) begin
                        a_sh_p1[j] <= a_sh_p1[j-1];
                        b_sh_p1[j] <= b_sh_p1[j-1];
                        v_sh_p1[j] <= v_sh_p1[j-1];
                    end
                end
            end

            assign a_sk[r] = a_sh_p1[r-1];
            assign b_sk[r] = b_sh_p1[r-1];
            assign v_sk[r] = v_sh_p1[r-1];
        end
    end

`ifdef SKEW_FEEDER_OUTREG_EN
    // Stage p1 -> p2: optional output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            a_west  <= '0;
            b_north <= '0;
            a_vld   <= '0;
            b_vld   <= '0;
        end else begin
            for (int r = 0; r < ARRAY_DIM; r++) begin
                a_west[r*DATA_WIDTH +: DATA_WIDTH]  <= a_sk[r];
                b_north[r*DATA_WIDTH +: DATA_WIDTH] <= b_sk[r];
            end
            a_vld <= v_sk;
            b_vld <= v_sk;
        end
    end
`else
    always_comb begin
        a_west  = '0;
        b_north = '0;
        for (int r = 0; r < ARRAY_DIM; r++) begin
            a_west[r*DATA_WIDTH +: DATA_WIDTH]  = a_sk[r];
            b_north[r*DATA_WIDTH +: DATA_WIDTH] = b_sk[r];
        end
    end
    assign a_vld = v_sk;
    assign b_vld = v_sk;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder (N=4, DATA_WIDTH=8).
// The buffer model answers each read with A[r][k]=16r+k and B[k][c]=16k+c,
// and pushes the expected lane outputs into per-lane queues. The checker pops
// those entries when the corresponding lane is due.
module tb_systolic_skew_feeder;
    localparam int N  = 4;
    localparam int DW = 8;
`ifdef SKEW_FEEDER_OUTREG_EN
    localparam int OREG = 1;
`else
    localparam int OREG = 0;
`endif
    localparam int DONE_EDGES = 3 * N + 1 + OREG;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sys_clr = 1'b0;
    logic            sys_start = 1'b0;
    logic            sys_done, buf_rd, pe_clear;
    logic [1:0]      buf_addr;
    logic [N*DW-1:0] a_col = '0;
    logic [N*DW-1:0] b_row = '0;
    logic [N*DW-1:0] a_west, b_north;
    logic [N-1:0]    a_vld, b_vld;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int rd_k   = 0;
    bit chk_en = 0;

    typedef struct {
        int          due;
        logic [7:0]  a;
        logic [7:0]  b;
    } exp_t;
    exp_t exp_q [N][$];

    systolic_skew_feeder #(.ARRAY_DIM(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .sys_clr(sys_clr), .sys_start(sys_start),
        .sys_done(sys_done), .buf_rd(buf_rd), .buf_addr(buf_addr),
        .a_col(a_col), .b_row(b_row), .a_west(a_west), .b_north(b_north),
        .a_vld(a_vld), .b_vld(b_vld), .pe_clear(pe_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic clear_queues();
        for (int r = 0; r < N; r++) exp_q[r].delete();
    endtask

    // Buffer model with one-cycle read latency; garbage is driven when idle.
    logic       rd_n;
    logic [1:0] addr_n;
    always begin
        @(negedge clk);
        rd_n   = buf_rd;
        addr_n = buf_addr;
        if (rd_n) check("buf_addr", 64'(addr_n), 64'(rd_k));
        @(posedge clk);
        #1;
        if (rd_n) begin
            for (int r = 0; r < N; r++) begin
                a_col[r*DW +: DW] = 8'(16 * r + rd_k);
                b_row[r*DW +: DW] = 8'(16 * rd_k + r);
                exp_q[r].push_back('{due: cyc + r + OREG, a: 8'(16 * r + rd_k), b: 8'(16 * rd_k + r)});
            end
            rd_k++;
        end else begin
            a_col = $urandom;
            b_row = $urandom;
        end
    end

    // Lane checker
    exp_t e;
    bit   ev;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int r = 0; r < N; r++) begin
                ev = (exp_q[r].size() > 0) && (exp_q[r][0].due == cyc);
                check($sformatf("a_vld[%0d]", r), 64'(a_vld[r]), 64'(ev));
                check($sformatf("b_vld[%0d]", r), 64'(b_vld[r]), 64'(ev));
                if (ev) begin
                    e = exp_q[r].pop_front();
                    check($sformatf("a_west[%0d]", r), 64'(a_west[r*DW +: DW]), 64'(e.a));
                    check($sformatf("b_north[%0d]", r), 64'(b_north[r*DW +: DW]), 64'(e.b));
                end else begin
                    check($sformatf("a_west_pad[%0d]", r), 64'(a_west[r*DW +: DW]), 64'd0);
                    check($sformatf("b_north_pad[%0d]", r), 64'(b_north[r*DW +: DW]), 64'd0);
                end
                if ((exp_q[r].size() > 0) && (exp_q[r][0].due < cyc)) begin
                    check($sformatf("lane%0d_missed", r), 64'd0, 64'd1);
                    void'(exp_q[r].pop_front());
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 64'(sys_done), 64'd0);
        check({tag, "_rd"}, 64'(buf_rd), 64'd0);
        check({tag, "_addr"}, 64'(buf_addr), 64'd0);
        check({tag, "_awest"}, 64'(a_west), 64'd0);
        check({tag, "_bnorth"}, 64'(b_north), 64'd0);
        check({tag, "_vld"}, 64'({a_vld, b_vld}), 64'd0);
        check({tag, "_peclr"}, 64'(pe_clear), 64'd0);
    endtask

    task automatic start_run();
        @(posedge clk);
        #2;
        rd_k      = 0;
        sys_start = 1'b1;
    endtask

    // Expects sys_start sampled high at the next rising edge.
    task automatic wait_done();
        bit seen = 0;
        int i;
        @(posedge clk);
        for (i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("first_rd", 64'(buf_rd), 64'd1);
                check("first_addr", 64'(buf_addr), 64'd0);
                check("peclr_pulse", 64'(pe_clear), 64'd0);
            end
            if (sys_done) begin
                seen = 1;
                break;
            end
        end
        if (seen) check("done_latency", 64'(i), 64'(DONE_EDGES));
        else check("done_timeout", 64'd0, 64'd1);
        for (int r = 0; r < N; r++) check($sformatf("q_empty[%0d]", r), 64'(exp_q[r].size()), 64'd0);
    endtask

    task automatic stop_run();
        @(posedge clk);
        #2;
        sys_start = 1'b0;
        @(negedge clk);
        check("done_before_drop_edge", 64'(sys_done), 64'd1);
        @(negedge clk);
        check("done_after_drop", 64'(sys_done), 64'd0);
        check("rd_after_drop", 64'(buf_rd), 64'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("por");
        rst = 1'b0;
        chk_en = 1;
        repeat (2) @(negedge clk);

        // Nominal run and done handshake
        start_run();
        wait_done();
        repeat (5) begin
            @(negedge clk);
            check("done_hold", 64'(sys_done), 64'd1);
        end
        stop_run();

        // Asynchronous reset in the middle of FEED
        start_run();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        clear_queues();
        sys_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_after_rst", 64'(buf_rd), 64'd0);
        end

        // sys_clr has priority over sys_start
        @(posedge clk);
        #2;
        rd_k      = 0;
        sys_clr   = 1'b1;
        sys_start = 1'b1;
        @(negedge clk);
        check("clr_no_rd0", 64'(buf_rd), 64'd0);
        @(posedge clk);
        #2;
        sys_clr = 1'b0;
        @(negedge clk);
        check("pe_clear", 64'(pe_clear), 64'd1);
        check("clr_no_rd1", 64'(buf_rd), 64'd0);
        wait_done();
        stop_run();

        // Abort at cnt=6
        start_run();
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
        sys_start = 1'b0;
        @(negedge clk);
        check("abort_drain_rd", 64'(buf_rd), 64'd0);
        @(posedge clk);
        #2;
        clear_queues();
        repeat (15) begin
            @(negedge clk);
            check("abort_done", 64'(sys_done), 64'd0);
            check("abort_vld", 64'({a_vld, b_vld}), 64'd0);
            check("abort_rd", 64'(buf_rd), 64'd0);
        end

        // Restart after the abort
        start_run();
        wait_done();
        stop_run();

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected finish");
        $fatal(1);
    end
endmodule
